// File: rtl/conv_out_collector.sv
// Output stage of the CONV block: FWFT result FIFO toward a ready/valid consumer,
// plus per-frame sum/max statistics with a one-cycle frame_done pulse.
module conv_out_collector #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = DATA_W + $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic [SUM_W-1:0]  frame_sum,
  output logic [DATA_W-1:0] frame_max,
  output logic              overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_W:0] mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, push, pop, last_tag;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SUM_W-1:0]  acc_sum, sum_nxt, fsum_nxt, samp_sum;
  logic [DATA_W-1:0] acc_max, max_nxt, fmax_nxt, samp_max;

  // FIFO status: the extra wrap bit separates full from empty on equal indices
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && out_ready;
  assign push     = in_valid && (!full || pop);
  assign last_tag = (state == ACC) && (cnt == CNT_LAST);

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]][DATA_W-1:0];
  assign out_last  = empty ? 1'b0 : mem[rd_ptr[AW-1:0]][DATA_W];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {last_tag, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (in_valid && !push) overflow <= 1'b1;
    end
  end

  // Frame statistics FSM; dropped samples still count so frames stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_sum   <= '0;
      acc_max   <= '0;
      frame_sum <= '0;
      frame_max <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc_sum   <= sum_nxt;
      acc_max   <= max_nxt;
      frame_sum <= fsum_nxt;
      frame_max <= fmax_nxt;
    end
  end

  assign samp_sum = acc_sum + SUM_W'(in_data);
  assign samp_max = max_u(acc_max, in_data);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sum_nxt   = acc_sum;
    max_nxt   = acc_max;
    fsum_nxt  = frame_sum;
    fmax_nxt  = frame_max;
    case (state)
      IDLE, DONE: begin
        if (in_valid) begin
          sum_nxt   = SUM_W'(in_data);
          max_nxt   = in_data;
          cnt_nxt   = CNT_ONE;
          state_nxt = ACC;
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      ACC: begin
        if (in_valid) begin
          if (cnt == CNT_LAST) begin
            fsum_nxt  = samp_sum;
            fmax_nxt  = samp_max;
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            sum_nxt = samp_sum;
            max_nxt = samp_max;
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_conv_out_collector.sv
// Bench for conv_out_collector: output stream and frame statistics checked
// against a bench-side FIFO/frame model through scoreboard queues.
module tb_conv_out_collector;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 8;
  localparam int SUM_W     = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              frame_done;
  logic [SUM_W-1:0]  frame_sum;
  logic [DATA_W-1:0] frame_max;
  logic              overflow;

  conv_out_collector #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .frame_done(frame_done), .frame_sum(frame_sum),
    .frame_max(frame_max), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W:0]         sb[$];
  logic [SUM_W+DATA_W-1:0] fq[$];
  int   mdl_cnt = 0;
  int   fidx = 0;
  int   msum = 0;
  int   mmax = 0;
  logic mdl_ovf = 1'b0;
  logic done_exp = 1'b0;

  // Apply one cycle of stimulus, then advance the model to the post-edge state.
  task automatic drive(input logic r, input logic v, input logic [DATA_W-1:0] d,
                       input logic rdy);
    logic pop_m, acc, last;
    rst = r; in_valid = v; in_data = d; out_ready = rdy;
    @(posedge clk); #1;
    if (r) begin
      sb.delete(); fq.delete();
      mdl_cnt = 0; fidx = 0; msum = 0; mmax = 0; mdl_ovf = 1'b0; done_exp = 1'b0;
    end else begin
      pop_m = (mdl_cnt != 0) && rdy;
      last  = (fidx == FRAME_LEN - 1);
      acc   = v && ((mdl_cnt < DEPTH) || pop_m);
      done_exp = 1'b0;
      if (v) begin
        if (acc) sb.push_back({last, d});
        else     mdl_ovf = 1'b1;
        if (fidx == 0) begin msum = d; mmax = d; end
        else begin msum += d; if (d > mmax) mmax = d; end
        if (last) begin
          fq.push_back({SUM_W'(msum), DATA_W'(mmax)});
          fidx = 0;
          done_exp = 1'b1;
        end else fidx++;
      end
      mdl_cnt = mdl_cnt + int'(acc) - int'(pop_m);
    end
  endtask

  // Scoreboard side: compare DUT output stream and frame pulses at mid-cycle.
  always @(negedge clk) begin
    logic [DATA_W:0]         e;
    logic [SUM_W+DATA_W-1:0] f;
    if (!rst) begin
      vectors++;
      if (out_valid !== (mdl_cnt != 0)) begin
        miscompares++;
        $display("FAIL out_valid: got %b want %b", out_valid, (mdl_cnt != 0));
      end
      vectors++;
      if (overflow !== mdl_ovf) begin
        miscompares++;
        $display("FAIL overflow: got %b want %b", overflow, mdl_ovf);
      end
      vectors++;
      if (frame_done !== done_exp) begin
        miscompares++;
        $display("FAIL frame_done: got %b want %b", frame_done, done_exp);
      end
      if (done_exp && fq.size() != 0) begin
        f = fq.pop_front();
        vectors++;
        if ({frame_sum, frame_max} !== f) begin
          miscompares++;
          $display("FAIL frame_stats: got sum %0d max %0d want sum %0d max %0d",
                   frame_sum, frame_max, f[SUM_W+DATA_W-1:DATA_W], f[DATA_W-1:0]);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL out_stream: got data %0d with no entry expected", out_data);
        end else begin
          e = sb.pop_front();
          if ({out_last, out_data} !== e) begin
            miscompares++;
            $display("FAIL out_stream: got last %b data %0d want last %b data %0d",
                     out_last, out_data, e[DATA_W], e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  task automatic drain();
    int guard = 0;
    while (mdl_cnt != 0 && guard < 40) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      guard++;
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    vectors++;
    if ({out_valid, out_data, out_last, frame_done, frame_sum, frame_max, overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_init: outputs got %b want all 0",
               {out_valid, out_data, out_last, frame_done, frame_sum, frame_max, overflow});
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'd200, 1'b0);
    drive(1'b1, 1'b1, 8'd200, 1'b0);
    drive(1'b1, 1'b1, 8'd200, 1'b0);
    vectors++;
    if ({out_valid, out_data, out_last, frame_done, frame_sum, frame_max, overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: outputs got %b want all 0",
               {out_valid, out_data, out_last, frame_done, frame_sum, frame_max, overflow});
    end
    for (int i = 0; i < FRAME_LEN; i++) drive(1'b0, 1'b1, 8'd3, 1'b1);
    vectors++;
    if (frame_done !== 1'b1 || frame_sum !== 11'd24 || frame_max !== 8'd3) begin
      miscompares++;
      $display("FAIL reset_frame: done %b sum %0d max %0d want 1 24 3",
               frame_done, frame_sum, frame_max);
    end
    drain();
  endtask

  task automatic test_single_frame();
    for (int i = 1; i <= FRAME_LEN; i++) drive(1'b0, 1'b1, DATA_W'(i), 1'b1);
    vectors++;
    if (frame_done !== 1'b1 || frame_sum !== 11'd36 || frame_max !== 8'd8) begin
      miscompares++;
      $display("FAIL single_frame: done %b sum %0d max %0d want 1 36 8",
               frame_done, frame_sum, frame_max);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'd8 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL single_last: valid %b data %0d last %b want 1 8 1",
               out_valid, out_data, out_last);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    vectors++;
    if (frame_done !== 1'b0 || frame_sum !== 11'd36) begin
      miscompares++;
      $display("FAIL single_hold: done %b sum %0d want 0 36", frame_done, frame_sum);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < FRAME_LEN; i++) drive(1'b0, 1'b1, 8'd255, 1'b1);
    vectors++;
    if (frame_done !== 1'b1 || frame_sum !== 11'd2040 || frame_max !== 8'd255) begin
      miscompares++;
      $display("FAIL b2b_frame_a: done %b sum %0d max %0d want 1 2040 255",
               frame_done, frame_sum, frame_max);
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      drive(1'b0, 1'b1, (i % 2) ? 8'd9 : 8'd0, 1'b1);
      if (i % 3 == 1 && i != FRAME_LEN - 1) drive(1'b0, 1'b0, '0, 1'b1);
    end
    vectors++;
    if (frame_done !== 1'b1 || frame_sum !== 11'd36 || frame_max !== 8'd9) begin
      miscompares++;
      $display("FAIL b2b_frame_b: done %b sum %0d max %0d want 1 36 9",
               frame_done, frame_sum, frame_max);
    end
    drain();
  endtask

  task automatic test_full();
    for (int i = 10; i < 20; i++) begin
      drive(1'b0, 1'b1, DATA_W'(i), 1'b0);
      if (i == 17) begin
        vectors++;
        if (overflow !== 1'b0 || out_data !== 8'd10) begin
          miscompares++;
          $display("FAIL full_fill: overflow %b head %0d want 0 10", overflow, out_data);
        end
      end
      if (i == 18) begin
        vectors++;
        if (overflow !== 1'b1) begin
          miscompares++;
          $display("FAIL full_overflow: got %b want 1", overflow);
        end
      end
    end
    drain();
  endtask

  task automatic test_full_simul();
    int n = 0;
    for (int i = 40; i < 48; i++) drive(1'b0, 1'b1, DATA_W'(i), 1'b0);
    drive(1'b0, 1'b1, 8'd50, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    while (out_valid && n < 20) begin
      n++;
      drive(1'b0, 1'b0, '0, 1'b1);
    end
    vectors++;
    if (n !== 8 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL full_simul: drained %0d overflow %b want 8 1", n, overflow);
    end
  endtask

  task automatic test_wrap();
    int sent = 0, cyc = 0, pulses = 0;
    logic v, rdy;
    drive(1'b1, 1'b0, '0, 1'b0);
    while (sent < 40 && cyc < 1000) begin
      v   = ($urandom_range(0, 1) == 1) && (mdl_cnt < DEPTH);
      rdy = ($urandom_range(0, 3) != 0);
      drive(1'b0, v, DATA_W'($urandom_range(0, 255)), rdy);
      if (v) sent++;
      if (frame_done) pulses++;
      cyc++;
    end
    drain();
    vectors++;
    if (sent != 40 || pulses != 5 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap: sent %0d pulses %0d overflow %b want 40 5 0",
               sent, pulses, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full();
    test_full_simul();
    test_wrap();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d expected outputs never seen, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
